and_input_debounce: RTL and testbench
=====================================

Name: and_input_debounce

Overview:
- Input-conditioning stage that sits directly upstream of and_gate.
- Takes two raw, asynchronous, possibly bouncing inputs and synchronises each one into the clock domain.
- Debounces each channel independently and drives the clean levels onto and_gate's a and b inputs.
- Emits a one-cycle change pulse per channel, so downstream logic can sample the gate output only after a settled input change.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clock edges the synchronised input must differ from the current output before the output updates. Legal range 1..255. Counter width is sized internally ($clog2) to hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- a_raw  input  1  raw asynchronous input, channel A.
- b_raw  input  1  raw asynchronous input, channel B.
- a  output  1  debounced, registered level for channel A; connects to and_gate.a.
- b  output  1  debounced, registered level for channel B; connects to and_gate.b.
- a_chg  output  1  one-cycle pulse, high in the cycle in which a takes a new value.
- b_chg  output  1  one-cycle pulse, high in the cycle in which b takes a new value.

Behaviour:
- Reset: on any rising edge with rst_n=0, all of the following go to 0: both synchroniser stages, a, b, a_chg, b_chg and both counters. Reset overrides all other activity, including a count in progress; the partial count is discarded.
- Per-channel pipeline, with the two channels fully independent and identical:
  - Two-flop synchroniser: x_raw -> s1 -> s2. Only s2 is used further.
  - mismatch = (s2 != x).
  - If mismatch=0: counter <= 0, x holds.
  - If mismatch=1 and counter < DEBOUNCE_CYCLES-1: counter increments, x holds.
  - If mismatch=1 and counter == DEBOUNCE_CYCLES-1: x <= s2, counter <= 0, x_chg <= 1.
  - x_chg is 0 in every cycle other than the update cycle, so it is never high for two consecutive cycles.
- Latency: raw change stable before edge k -> s1 updates at k, s2 at k+1 -> x updates at edge k+1+DEBOUNCE_CYCLES. This is DEBOUNCE_CYCLES+2 edges; 6 edges at the default.
- Glitch rejection: if s2 returns to x before the count completes, the counter clears to 0 and x does not change. A subsequent mismatch restarts counting from 0.
- DEBOUNCE_CYCLES=1: x updates on the first mismatching edge, giving a latency of 3 edges.
- Raw input high through reset: outputs stay 0 during reset. After rst_n rises, the output goes to 1 after the normal latency, with x_chg pulsing.
- Simultaneous changes on both channels are handled independently. a_chg and b_chg may pulse in the same cycle.
- No combinational path from any input to any output; all outputs are registered.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Test Plan (DEBOUNCE_CYCLES=4, clk period 10 ns, inputs changed 2 ns after a rising edge):
- Reset: hold rst_n=0 for 3 edges with a_raw=b_raw=1 -> a=b=a_chg=b_chg=0 throughout. Release rst_n -> a and b rise together exactly 6 edges after release, and a_chg and b_chg pulse high for that one cycle only.
- Clean step: a_raw 0->1 before edge k, b_raw=0 -> a=0 through edge k+4, a=1 from edge k+5, a_chg=1 only in the cycle after edge k+5, b and b_chg remain 0. Feed a,b into and_gate -> y=0.
- Glitch rejection: pulse a_raw high for 3 cycles, then low -> a never changes and a_chg never asserts. Repeat with a 4-cycle pulse -> a goes 1 then back to 0, with one a_chg pulse per transition.
- Bounce: toggle b_raw every cycle for 10 cycles, then hold at 1 -> b stays 0 during toggling and goes to 1 exactly 6 edges after the final stable edge, with a single b_chg pulse.
- Truth table through and_gate: drive (a_raw,b_raw) through 00, 01, 10, 11, holding each for 10 cycles -> after each settles, (a,b) matches the raw pair and y equals a&b, i.e. 0,0,0,1. Use $fatal on any mismatch.
- Reset mid-count: a_raw 0->1, then assert rst_n=0 for 1 edge at the third mismatching edge -> a stays 0 and the counter restarts. a rises 6 edges after the reset edge, since a_raw is still 1.

Source files
------------

// File: rtl/and_input_debounce.sv
// Two-channel input conditioner for and_gate: each raw input goes through a
// 2-flop synchroniser and a consecutive-mismatch debouncer with a change pulse.

module and_input_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_chg
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;
    logic             w_done;

    assign w_mismatch = (r_sync2 != r_level);
    assign w_done     = w_mismatch && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_chg   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_chg   <= w_done;
            // Any edge where s2 agrees with the output discards the partial count.
            if (!w_mismatch || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_level <= r_sync2;
            end
        end
    end

    assign o_level = r_level;
    assign o_chg   = r_chg;

endmodule

module and_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_chg,
    output logic b_chg
);

    // Counter must hold DEBOUNCE_CYCLES-1; keep at least one bit for the 1-cycle case.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    and_input_debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_raw  (a_raw),
        .o_level(a),
        .o_chg  (a_chg)
    );

    and_input_debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_raw  (b_raw),
        .o_level(b),
        .o_chg  (b_chg)
    );

endmodule

// File: tb/tb_and_input_debounce.sv
// Randomised and directed bench for and_input_debounce with a windowed
// reference model feeding an expected queue checked by a per-cycle monitor.

module tb_and_input_debounce;

    localparam int DC = 4;

    logic clk;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic a_chg;
    logic b_chg;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    logic [3:0] exp_q[$];

    and_input_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a_raw(a_raw),
        .b_raw(b_raw),
        .a    (a),
        .b    (b),
        .a_chg(a_chg),
        .b_chg(b_chg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: raw arrives at the debouncer two edges late; the level
    // flips once the last DC edges since reset/last flip all disagreed with it.
    bit line0 [2];
    bit line1 [2];
    bit hist  [2][$];
    bit mx    [2];
    bit mchg  [2];

    task automatic model_step(input bit rst, input bit ra, input bit rb);
        bit raw [2];
        bit seen;
        bit all_opp;
        raw[0] = ra;
        raw[1] = rb;
        for (int ch = 0; ch < 2; ch++) begin
            if (rst) begin
                line0[ch] = 1'b0;
                line1[ch] = 1'b0;
                hist[ch].delete();
                mx[ch]   = 1'b0;
                mchg[ch] = 1'b0;
            end else begin
                seen      = line1[ch];
                line1[ch] = line0[ch];
                line0[ch] = raw[ch];
                hist[ch].push_back(seen);
                if (hist[ch].size() > DC) void'(hist[ch].pop_front());
                all_opp = (hist[ch].size() == DC);
                foreach (hist[ch][i]) if (hist[ch][i] == mx[ch]) all_opp = 1'b0;
                mchg[ch] = 1'b0;
                if (all_opp) begin
                    mx[ch]   = ~mx[ch];
                    mchg[ch] = 1'b1;
                    hist[ch].delete();
                end
            end
        end
        exp_q.push_back({mx[0], mx[1], mchg[0], mchg[1]});
    endtask

    // Driver: model the edge just taken with the inputs that were applied,
    // then apply the next inputs 2 ns after the edge.
    bit cur_rst = 1'b1;
    bit cur_a   = 1'b0;
    bit cur_b   = 1'b0;

    task automatic drive_cycle(input bit rst, input bit ra, input bit rb);
        @(posedge clk);
        #2;
        model_step(cur_rst, cur_a, cur_b);
        cycle_no++;
        rst_n   = ~rst;
        a_raw   = ra;
        b_raw   = rb;
        cur_rst = rst;
        cur_a   = ra;
        cur_b   = rb;
    endtask

    task automatic hold(input int n, input bit rst, input bit ra, input bit rb);
        for (int i = 0; i < n; i++) drive_cycle(rst, ra, rb);
    endtask

    // Scoreboard monitor
    initial begin
        logic [3:0] exp;
        logic [3:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {a, b, a_chg, b_chg};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL outputs{a,b,a_chg,b_chg} cycle=%0d actual=%b expected=%b",
                             cycle_no, act, exp);
                end
                checks++;
                if ((a & b) !== (exp[3] & exp[2])) begin
                    failures++;
                    $display("FAIL and_gate_y cycle=%0d actual=%b expected=%b",
                             cycle_no, a & b, exp[3] & exp[2]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int  a_left;
        int  b_left;
        bit  ra;
        bit  rb;
        rst_n = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b1;
        cur_a = 1'b1;
        cur_b = 1'b1;

        // Raw high through reset, then release.
        hold(3, 1'b1, 1'b1, 1'b1);
        hold(12, 1'b0, 1'b1, 1'b1);
        hold(3, 1'b1, 1'b0, 1'b0);
        hold(10, 1'b0, 1'b0, 1'b0);

        // Clean step on A.
        hold(12, 1'b0, 1'b1, 1'b0);
        hold(12, 1'b0, 1'b0, 1'b0);

        // Glitches of length 3 (rejected) and 4 (accepted).
        hold(3, 1'b0, 1'b1, 1'b0);
        hold(12, 1'b0, 1'b0, 1'b0);
        hold(4, 1'b0, 1'b1, 1'b0);
        hold(14, 1'b0, 1'b0, 1'b0);

        // Bounce on B, then settle high.
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, (i % 2) == 0);
        hold(12, 1'b0, 1'b0, 1'b1);

        // Truth table through and_gate.
        hold(10, 1'b0, 1'b0, 1'b0);
        hold(10, 1'b0, 1'b0, 1'b1);
        hold(10, 1'b0, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b1, 1'b1);

        // Reset landing on the third mismatching edge of a rising A.
        hold(12, 1'b0, 1'b0, 1'b0);
        hold(4, 1'b0, 1'b1, 1'b0);
        hold(1, 1'b1, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b1, 1'b0);

        // Random runs of varying length on both channels with rare resets.
        ra = 1'b1;
        rb = 1'b0;
        a_left = 0;
        b_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (a_left == 0) begin
                ra     = ~ra;
                a_left = $urandom_range(1, 8);
            end
            if (b_left == 0) begin
                rb     = ~rb;
                b_left = $urandom_range(1, 8);
            end
            a_left--;
            b_left--;
            if ($urandom_range(0, 199) == 0) begin
                hold($urandom_range(1, 3), 1'b1, ra, rb);
            end else begin
                drive_cycle(1'b0, ra, rb);
            end
        end
        hold(12, 1'b0, ra, rb);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
